// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
//   NopInst        : word presented to decode when no instruction is live
//   DefaultResetPc : default PC of the first fetch after reset
//   DefaultFqDepth : default fetch-queue depth (power of 2, >= 2)
package inst_fetch_unit_pkg;

  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultFqDepth = 2;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Synchronous FIFO used for both the fetched-word queue and the request-PC queue.
//   clk_i, rst_n : clock, asynchronous active-low reset
//   push_i       : write wdata_i at the tail (accepted when not full, or full with a pop)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO; overrides push and pop
//   rdata_o      : head entry (undefined when empty)
//   empty_o, full_o, count_o : occupancy status
module inst_fetch_unit_fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AddrW+1)'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
      cnt_q <= cnt_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, issues in-order word reads over req/gnt/rvalid, buffers returned words
// and presents them to decode.
//   clk_i, rst_n               : clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o   : read request and word-aligned address
//   imem_gnt_i                 : request accepted this cycle
//   imem_rvalid_i/imem_rdata_i : in-order read response
//   redirect_valid_i/_pc_i     : control-flow redirect from EX
//   id_stall_i                 : decode is not consuming the current word
//   inst_valid_o/inst_o/inst_pc_o : instruction to decode (NOP when not valid)
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc = DefaultResetPc,
  parameter int unsigned FqDepth = DefaultFqDepth
) (
  input  logic        clk_i,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned CntW = $clog2(FqDepth) + 1;

  fetch_state_e    state_q, state_d;
  logic            imem_req_q;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] out_q, out_d;    // granted, response not yet seen
  logic [CntW-1:0] disc_q, disc_d;  // responses still to be dropped after a redirect
  logic [CntW-1:0] occ_d;
  logic [CntW:0]   credit_sum;

  logic            issue, rv_keep, rv_drop, dq_pop;
  logic [63:0]     dq_rdata;
  logic            dq_empty, dq_full;
  logic [CntW-1:0] dq_count;
  logic [31:0]     pcf_rdata;
  logic            pcf_empty, pcf_full;
  logic [CntW-1:0] pcf_count;

  assign issue   = imem_req_q && imem_gnt_i;
  assign rv_keep = imem_rvalid_i && (disc_q == '0);
  assign rv_drop = imem_rvalid_i && (disc_q != '0);
  assign dq_pop  = !dq_empty && !id_stall_i;

  // Request PCs: only non-discarded requests live here, since a redirect flushes it and
  // every later grant is younger than all responses still owed to the discard counter.
  inst_fetch_unit_fetch_queue #(
    .Width (32),
    .Depth (FqDepth)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (issue && !redirect_valid_i),
    .pop_i   (rv_keep && !redirect_valid_i),
    .flush_i (redirect_valid_i),
    .wdata_i (pc_q),
    .rdata_o (pcf_rdata),
    .empty_o (pcf_empty),
    .full_o  (pcf_full),
    .count_o (pcf_count)
  );

  inst_fetch_unit_fetch_queue #(
    .Width (64),
    .Depth (FqDepth)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (rv_keep && !redirect_valid_i),
    .pop_i   (dq_pop),
    .flush_i (redirect_valid_i),
    .wdata_i ({pcf_rdata, imem_rdata_i}),
    .rdata_o (dq_rdata),
    .empty_o (dq_empty),
    .full_o  (dq_full),
    .count_o (dq_count)
  );

  // Credit = outstanding + queued words; it only grows on issue and shrinks on pop or drop,
  // so the next state is decided from the post-edge sum.
  always_comb begin
    out_d  = out_q + CntW'(issue) - CntW'(imem_rvalid_i);
    disc_d = disc_q - CntW'(rv_drop);
    occ_d  = dq_count + CntW'(rv_keep) - CntW'(dq_pop);
    pc_d   = issue ? pc_q + 32'd4 : pc_q;
    if (redirect_valid_i) begin
      disc_d = out_d;
      occ_d  = '0;
      pc_d   = align_word(redirect_pc_i);
    end
    credit_sum = {1'b0, out_d} + {1'b0, occ_d};
    state_d    = (credit_sum < (CntW+1)'(FqDepth)) ? StReq : StHold;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      imem_req_q <= 1'b0;
      pc_q       <= ResetPc;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= (state_d == StReq);
      pc_q       <= pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = !dq_empty;
  assign inst_o       = dq_empty ? NopInst : dq_rdata[31:0];
  assign inst_pc_o    = dq_empty ? 32'h0 : dq_rdata[63:32];

  logic unused_sigs;
  assign unused_sigs = ^{pcf_empty, pcf_full, pcf_count, state_q};

  // The credit rule keeps a response from ever arriving while the queue is full.
  assert property (@(posedge clk_i) disable iff (!rst_n) !(imem_rvalid_i && dq_full))
    else $error("fetch queue overflow");

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int FQ = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        id_stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  inst_fetch_unit #(
    .ResetPc (RST_PC),
    .FqDepth (FQ)
  ) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_stall_i       (id_stall_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc;
  int first_valid;

  // stimulus controls, applied by step() at each falling edge
  logic        stall_c, gnt_c, redir_c;
  logic [31:0] redir_pc_c;
  int          lat_c;

  // memory and stream model
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] cons_q[$];
  logic [31:0] exp_pc, fetch_pc, prev_pc, prev_inst;
  logic        expect_inv, prev_hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_addr.delete();
    pend_cyc.delete();
    cons_q.delete();
    exp_pc = RST_PC;
    fetch_pc = RST_PC;
    expect_inv = 1'b0;
    prev_hold = 1'b0;
    redir_c = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    id_stall_i = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    cyc = 0;
    first_valid = -1;
  endtask

  // One cycle: check this cycle's outputs against the stream model, then drive the inputs
  // that the next rising edge samples and advance the model accordingly.
  task automatic step();
    logic consumed;
    @(negedge clk_i);
    cyc++;
    if (inst_valid_o && first_valid < 0) first_valid = cyc;
    if (expect_inv) chk1("valid_after_redirect", inst_valid_o, 1'b0);
    if (prev_hold) begin
      chk1("stall_hold_valid", inst_valid_o, 1'b1);
      chk("stall_hold_pc", inst_pc_o, prev_pc);
      chk("stall_hold_inst", inst_o, prev_inst);
    end
    if (inst_valid_o) begin
      chk("inst_pc", inst_pc_o, exp_pc);
      chk("inst_word", inst_o, mem_word(exp_pc));
    end else begin
      chk("nop_when_idle", inst_o, NOP);
    end
    if (imem_req_o) chk("imem_addr", imem_addr_o, fetch_pc);
    chk1("credit_cap", pend_addr.size() <= FQ, 1'b1);

    consumed = inst_valid_o && !stall_c && !redir_c;
    if (consumed) begin
      cons_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    prev_hold = inst_valid_o && stall_c && !redir_c;
    prev_pc = inst_pc_o;
    prev_inst = inst_o;

    id_stall_i = stall_c;
    redirect_valid_i = redir_c;
    redirect_pc_i = redir_pc_c;
    if (pend_addr.size() > 0 && pend_cyc[0] + lat_c <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = mem_word(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i = '0;
    end
    imem_gnt_i = gnt_c;
    if (imem_req_o && gnt_c) begin
      pend_addr.push_back(imem_addr_o);
      pend_cyc.push_back(cyc);
      fetch_pc = fetch_pc + 32'd4;
    end
    expect_inv = redir_c;
    if (redir_c) begin
      fetch_pc = redir_pc_c & 32'hFFFF_FFFC;
      exp_pc = fetch_pc;
    end
    redir_c = 1'b0;
  endtask

  initial begin
    int n;
    stall_c = 1'b0;
    gnt_c = 1'b1;
    redir_pc_c = '0;
    lat_c = 1;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk1("reset_req", imem_req_o, 1'b0);
    chk("reset_addr", imem_addr_o, RST_PC);
    chk1("reset_valid", inst_valid_o, 1'b0);
    chk("reset_inst", inst_o, NOP);
    chk("reset_inst_pc", inst_pc_o, 32'h0);

    // first word: granted in cycle 1, returned in cycle 2, visible in cycle 3
    release_reset();
    n = 0;
    while (first_valid < 0 && n < 10) begin step(); n++; end
    chk("first_valid_cycle", first_valid, 3);
    chk("first_inst_pc", inst_pc_o, 32'h0);
    repeat (10) step();

    // decode stall with a full queue: fetch must back off and hold the output
    stall_c = 1'b1;
    repeat (5) step();
    chk1("stall_full_req", imem_req_o, 1'b0);
    chk1("stall_full_valid", inst_valid_o, 1'b1);
    stall_c = 1'b0;
    repeat (8) step();

    // redirect with no credit used, then the request waits 4 cycles for a grant
    gnt_c = 1'b0;
    n = 0;
    while (pend_addr.size() != 0 && n < 20) begin step(); n++; end
    chk1("drain_before_redirect", pend_addr.size() == 0, 1'b1);
    redir_c = 1'b1;
    redir_pc_c = 32'h0000_0100;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("req_pending_no_gnt", imem_req_o, 1'b1);
      chk("addr_hold_no_gnt", imem_addr_o, 32'h0000_0100);
    end
    gnt_c = 1'b1;
    n = 0;
    while (!inst_valid_o && n < 20) begin step(); n++; end
    chk("pc_after_redirect_100", inst_pc_o, 32'h0000_0100);
    repeat (6) step();

    // two words outstanding at redirect: both responses dropped, unaligned target
    lat_c = 3;
    n = 0;
    while (pend_addr.size() != 2 && n < 30) begin step(); n++; end
    chk1("two_outstanding", pend_addr.size() == 2, 1'b1);
    redir_c = 1'b1;
    redir_pc_c = 32'h0000_0203;
    step();
    n = 0;
    while (!imem_req_o && n < 20) begin step(); n++; end
    chk("addr_after_redirect_203", imem_addr_o, 32'h0000_0200);
    n = 0;
    while (!inst_valid_o && n < 20) begin step(); n++; end
    chk("pc_after_redirect_203", inst_pc_o, 32'h0000_0200);
    chk("word_after_redirect_203", inst_o, mem_word(32'h0000_0200));

    // mixed stall / grant pattern
    lat_c = 2;
    for (int i = 0; i < 40; i++) begin
      stall_c = (i % 3 == 0);
      gnt_c = (i % 4 != 1);
      step();
    end
    stall_c = 1'b0;
    gnt_c = 1'b1;
    lat_c = 1;
    repeat (4) step();

    // PC wrap at the top of the address space
    cons_q.delete();
    redir_c = 1'b1;
    redir_pc_c = 32'hFFFF_FFFF;
    step();
    n = 0;
    while (cons_q.size() < 2 && n < 20) begin step(); n++; end
    chk1("wrap_consumed_two", cons_q.size() >= 2, 1'b1);
    if (cons_q.size() >= 2) begin
      chk("wrap_first_pc", cons_q[0], 32'hFFFF_FFFC);
      chk("wrap_second_pc", cons_q[1], 32'h0000_0000);
    end
    repeat (5) step();

    // asynchronous reset in the middle of traffic
    @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_reset_req", imem_req_o, 1'b0);
    chk1("async_reset_valid", inst_valid_o, 1'b0);
    chk("async_reset_inst", inst_o, NOP);
    chk("async_reset_inst_pc", inst_pc_o, 32'h0);
    chk("async_reset_addr", imem_addr_o, RST_PC);
    model_reset();
    repeat (2) @(negedge clk_i);
    release_reset();
    n = 0;
    while (first_valid < 0 && n < 10) begin step(); n++; end
    chk("resume_valid_cycle", first_valid, 3);
    chk("resume_inst_pc", inst_pc_o, RST_PC);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
